// File: rtl/mips_pkg.sv
// Shared pipeline definitions for the MIPS-style core.
// Used by the control unit and the ID/EX stage.
package mips_pkg;

  localparam int RW = 5;
  localparam int FW = 6;

  localparam logic [FW-1:0] NOPF = 6'b000000;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10
  } pcsrc_e;

  typedef struct packed {
    logic memRead;
    logic memWrite;
    logic aluSrc;
    logic regDst;
    logic regWrite;
    logic memToReg;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard check: the EX-stage load writes a
// register that the ID-stage instruction reads.
module load_use_detect
  import mips_pkg::*;
(
  input  logic          exValid,
  input  logic          exMemRead,
  input  logic [RW-1:0] exRt,
  input  logic [RW-1:0] rs,
  input  logic [RW-1:0] rt,
  output logic          hazard
);

  logic rt_nz;
  logic rt_hit;

  assign rt_nz  = |exRt;
  assign rt_hit = (exRt == rs) | (exRt == rt);
  assign hazard = exValid & exMemRead & rt_nz & rt_hit;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall,
// branch/jump flush and a saturating stall counter.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memRead,
  input  logic          memWrite,
  input  logic          aluSrc,
  input  logic          regDst,
  input  logic          regWrite,
  input  logic          memToReg,
  input  logic [FW-1:0] funcIn,
  input  logic [1:0]    pcSrc,
  input  logic [DW-1:0] readData1,
  input  logic [DW-1:0] readData2,
  input  logic [DW-1:0] signExt,
  input  logic [RW-1:0] rs,
  input  logic [RW-1:0] rt,
  input  logic [RW-1:0] rd,
  output logic          exMemRead,
  output logic          exMemWrite,
  output logic          exAluSrc,
  output logic          exRegDst,
  output logic          exRegWrite,
  output logic          exMemToReg,
  output logic [FW-1:0] exFunc,
  output logic [DW-1:0] exData1,
  output logic [DW-1:0] exData2,
  output logic [DW-1:0] exImm,
  output logic [RW-1:0] exRs,
  output logic [RW-1:0] exRt,
  output logic [RW-1:0] exRd,
  output logic          exValid,
  output logic          stall,
  output logic          ifIdFlush,
  output logic [15:0]   stallCount
);

  ctrl_t         ctrl_in;
  ctrl_t         ctrl_q, ctrl_d;
  logic [FW-1:0] func_q, func_d;
  logic [DW-1:0] data1_q, data1_d;
  logic [DW-1:0] data2_q, data2_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [RW-1:0] rs_q, rs_d;
  logic [RW-1:0] rt_q, rt_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          valid_q, valid_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          hazard;

  assign ctrl_in = '{
    memRead:  memRead,
    memWrite: memWrite,
    aluSrc:   aluSrc,
    regDst:   regDst,
    regWrite: regWrite,
    memToReg: memToReg
  };

  load_use_detect u_lud (
    .exValid   (valid_q),
    .exMemRead (ctrl_q.memRead),
    .exRt      (rt_q),
    .rs        (rs),
    .rt        (rt),
    .hazard    (hazard)
  );

  assign stall     = hazard;
  // A stall holds IF/ID, so it must not also be squashed.
  assign ifIdFlush = (pcSrc != PC_SEQ) & ~hazard;

  always_comb begin
    ctrl_d  = ctrl_q;
    func_d  = func_q;
    data1_d = data1_q;
    data2_d = data2_q;
    imm_d   = imm_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (hazard) begin
      ctrl_d  = CTRL_NOP;
      func_d  = NOPF;
      valid_d = 1'b0;
      cnt_d   = sat_inc(cnt_q);
    end else begin
      ctrl_d  = ctrl_in;
      func_d  = funcIn;
      data1_d = readData1;
      data2_d = readData2;
      imm_d   = signExt;
      rs_d    = rs;
      rt_d    = rt;
      rd_d    = rd;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= CTRL_NOP;
      func_q  <= NOPF;
      data1_q <= '0;
      data2_q <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      func_q  <= func_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign exMemRead  = ctrl_q.memRead;
  assign exMemWrite = ctrl_q.memWrite;
  assign exAluSrc   = ctrl_q.aluSrc;
  assign exRegDst   = ctrl_q.regDst;
  assign exRegWrite = ctrl_q.regWrite;
  assign exMemToReg = ctrl_q.memToReg;
  assign exFunc     = func_q;
  assign exData1    = data1_q;
  assign exData2    = data2_q;
  assign exImm      = imm_q;
  assign exRs       = rs_q;
  assign exRt       = rt_q;
  assign exRd       = rd_q;
  assign exValid    = valid_q;
  assign stallCount = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use,
// no-hazard cases, branch/jump flush, saturation.
module tb_id_ex_stage;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          memRead, memWrite, aluSrc;
  logic          regDst, regWrite, memToReg;
  logic [5:0]    funcIn;
  logic [1:0]    pcSrc;
  logic [DW-1:0] readData1, readData2, signExt;
  logic [4:0]    rs, rt, rd;
  logic          exMemRead, exMemWrite, exAluSrc;
  logic          exRegDst, exRegWrite, exMemToReg;
  logic [5:0]    exFunc;
  logic [DW-1:0] exData1, exData2, exImm;
  logic [4:0]    exRs, exRt, exRd;
  logic          exValid, stall, ifIdFlush;
  logic [15:0]   stallCount;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .memRead(memRead), .memWrite(memWrite),
    .aluSrc(aluSrc), .regDst(regDst),
    .regWrite(regWrite), .memToReg(memToReg),
    .funcIn(funcIn), .pcSrc(pcSrc),
    .readData1(readData1), .readData2(readData2),
    .signExt(signExt),
    .rs(rs), .rt(rt), .rd(rd),
    .exMemRead(exMemRead), .exMemWrite(exMemWrite),
    .exAluSrc(exAluSrc), .exRegDst(exRegDst),
    .exRegWrite(exRegWrite), .exMemToReg(exMemToReg),
    .exFunc(exFunc),
    .exData1(exData1), .exData2(exData2), .exImm(exImm),
    .exRs(exRs), .exRt(exRt), .exRd(exRd),
    .exValid(exValid), .stall(stall),
    .ifIdFlush(ifIdFlush), .stallCount(stallCount)
  );

  // ctl = {memRead,memWrite,aluSrc,regDst,regWrite,memToReg}
  task automatic drive(input logic [5:0] ctl,
                       input logic [5:0] f,
                       input logic [1:0] pcs,
                       input logic [4:0] s, t, d,
                       input logic [31:0] d1, d2, im);
    {memRead, memWrite, aluSrc,
     regDst, regWrite, memToReg} = ctl;
    funcIn = f; pcSrc = pcs;
    rs = s; rt = t; rd = d;
    readData1 = d1; readData2 = d2; signExt = im;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [5:0] ex_ctl();
    return {exMemRead, exMemWrite, exAluSrc,
            exRegDst, exRegWrite, exMemToReg};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(6'b111111, 6'h3f, 2'b10, 5'd5, 5'd5, 5'd9,
          32'hdead_beef, 32'h1234_5678, 32'hffff_0000);
    step();
    step();
    checks++;
    if (ex_ctl() !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 0", ex_ctl());
    end
    checks++;
    if ({exFunc, exData1, exData2, exImm, exRs, exRt, exRd,
         exValid} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h/%h exp 0",
               exFunc, exData1, exData2, exImm);
    end
    checks++;
    if (stall !== 1'b0 || stallCount !== 16'd0) begin
      errors++;
      $display("FAIL reset_stall got %b/%0d exp 0/0",
               stall, stallCount);
    end
    checks++;
    if (ifIdFlush !== 1'b1) begin
      errors++;
      $display("FAIL reset_flush got %b exp 1", ifIdFlush);
    end
    rst = 1'b0;
    drive(6'b0, 6'h0, 2'b00, 5'd0, 5'd0, 5'd0, 0, 0, 0);
  endtask

  task automatic test_load_use();
    // lw $5, 4($3)
    drive(6'b101011, 6'h20, 2'b00, 5'd3, 5'd5, 5'd0,
          32'd100, 32'd200, 32'd4);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_pre_stall got %b exp 0", stall);
    end
    step();
    // add $7, $5, $6
    drive(6'b000110, 6'h21, 2'b00, 5'd5, 5'd6, 5'd7,
          32'd11, 32'd22, 32'd0);
    checks++;
    if (stall !== 1'b1 || ifIdFlush !== 1'b0) begin
      errors++;
      $display("FAIL lu_stall got %b/%b exp 1/0",
               stall, ifIdFlush);
    end
    step();
    exp_cnt++;
    checks++;
    if (exValid !== 1'b0 || exFunc !== 6'h0 ||
        ex_ctl() !== 6'b0) begin
      errors++;
      $display("FAIL lu_bubble got v=%b f=%h c=%b exp 0/0/0",
               exValid, exFunc, ex_ctl());
    end
    checks++;
    if (exData1 !== 32'd100 || exRt !== 5'd5 ||
        exImm !== 32'd4) begin
      errors++;
      $display("FAIL lu_hold got %0d/%0d/%0d exp 100/5/4",
               exData1, exRt, exImm);
    end
    checks++;
    if (stall !== 1'b0 || stallCount !== 16'd1) begin
      errors++;
      $display("FAIL lu_count got %b/%0d exp 0/1",
               stall, stallCount);
    end
    step();
    checks++;
    if (exValid !== 1'b1 || exFunc !== 6'h21 ||
        exRd !== 5'd7 || exData1 !== 32'd11 ||
        ex_ctl() !== 6'b000110) begin
      errors++;
      $display("FAIL lu_add got v=%b f=%h rd=%0d d1=%0d c=%b exp 1/21/7/11/000110",
               exValid, exFunc, exRd, exData1, ex_ctl());
    end
  endtask

  task automatic test_no_hazard();
    // lw $0 then reader of $0
    drive(6'b101011, 6'h20, 2'b00, 5'd1, 5'd0, 5'd0,
          32'd1, 32'd2, 32'd3);
    step();
    drive(6'b000110, 6'h21, 2'b00, 5'd0, 5'd0, 5'd8,
          32'd4, 32'd5, 32'd0);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL nh_rt0 got %b exp 0", stall);
    end
    // sw $5 then reader of $5
    drive(6'b011000, 6'h20, 2'b00, 5'd2, 5'd5, 5'd0,
          32'd6, 32'd7, 32'd8);
    step();
    drive(6'b000110, 6'h21, 2'b00, 5'd5, 5'd5, 5'd9,
          32'd9, 32'd10, 32'd0);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL nh_store got %b exp 0", stall);
    end
    step();
    checks++;
    if (stallCount !== exp_cnt[15:0] || exRd !== 5'd9 ||
        exValid !== 1'b1) begin
      errors++;
      $display("FAIL nh_adv got cnt=%0d rd=%0d v=%b exp %0d/9/1",
               stallCount, exRd, exValid, exp_cnt);
    end
  endtask

  task automatic test_branch();
    // beq $8, $9 taken
    drive(6'b000000, 6'h22, 2'b01, 5'd8, 5'd9, 5'd0,
          32'hAA, 32'hBB, 32'h10);
    checks++;
    if (ifIdFlush !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL br_flush got %b/%b exp 1/0",
               ifIdFlush, stall);
    end
    step();
    checks++;
    if (exValid !== 1'b1 || exFunc !== 6'h22 ||
        exRs !== 5'd8 || exRt !== 5'd9 ||
        exImm !== 32'h10 || ex_ctl() !== 6'b0) begin
      errors++;
      $display("FAIL br_adv got v=%b f=%h rs=%0d rt=%0d imm=%h exp 1/22/8/9/10",
               exValid, exFunc, exRs, exRt, exImm);
    end
    // lw $4 then jump reading $4 while stalled
    drive(6'b101011, 6'h20, 2'b00, 5'd1, 5'd4, 5'd0,
          32'd1, 32'd2, 32'd3);
    step();
    drive(6'b000000, 6'h00, 2'b10, 5'd4, 5'd0, 5'd0,
          32'd0, 32'd0, 32'd0);
    checks++;
    if (stall !== 1'b1 || ifIdFlush !== 1'b0) begin
      errors++;
      $display("FAIL jmp_stall got %b/%b exp 1/0",
               stall, ifIdFlush);
    end
    step();
    exp_cnt++;
    checks++;
    if (ifIdFlush !== 1'b1 || stall !== 1'b0 ||
        stallCount !== exp_cnt[15:0]) begin
      errors++;
      $display("FAIL jmp_after got %b/%b/%0d exp 1/0/%0d",
               ifIdFlush, stall, stallCount, exp_cnt);
    end
    drive(6'b0, 6'h0, 2'b00, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step();
  endtask

  task automatic lu_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      drive(6'b101011, 6'h20, 2'b00, 5'd0, 5'd5, 5'd0,
            32'd0, 32'd0, 32'd0);
      step();
      drive(6'b000110, 6'h21, 2'b00, 5'd5, 5'd1, 5'd2,
            32'd0, 32'd0, 32'd0);
      step();
    end
  endtask

  task automatic test_saturation();
    int first;
    first = 65534 - exp_cnt;
    lu_pairs(first);
    checks++;
    if (stallCount !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_near got %h exp fffe", stallCount);
    end
    lu_pairs(1);
    checks++;
    if (stallCount !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hit got %h exp ffff", stallCount);
    end
    lu_pairs(4);
    checks++;
    if (stallCount !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold got %h exp ffff", stallCount);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(6'b101011, 6'h20, 2'b00, 5'd0, 5'd3, 5'd0,
          32'd0, 32'd0, 32'd0);
    step();
    drive(6'b000110, 6'h21, 2'b01, 5'd3, 5'd1, 5'd2,
          32'd0, 32'd0, 32'd0);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL rms_pre got %b exp 1", stall);
    end
    rst = 1'b1;
    step();
    checks++;
    if (exValid !== 1'b0 || stall !== 1'b0 ||
        stallCount !== 16'd0) begin
      errors++;
      $display("FAIL rms_after got v=%b s=%b c=%0d exp 0/0/0",
               exValid, stall, stallCount);
    end
    checks++;
    if (ifIdFlush !== 1'b1) begin
      errors++;
      $display("FAIL rms_flush got %b exp 1", ifIdFlush);
    end
    rst = 1'b0;
    step();
    checks++;
    if (exValid !== 1'b1 || exFunc !== 6'h21) begin
      errors++;
      $display("FAIL rms_resume got %b/%h exp 1/21",
               exValid, exFunc);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(6'b0, 6'h0, 2'b00, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_saturation();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DW, default 32, datapath width of register operands and immediate.
REQ-002 SHALL have ports: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-003 SHALL have ID-side control inputs, 1 bit each, from control unit: memRead, memWrite, aluSrc, regDst, regWrite, memToReg.
REQ-004 SHALL have inputs funcIn 6 (ALU function from control unit) and pcSrc 2 (00 sequential, 01 branch taken, 10 jump).
REQ-005 SHALL have data inputs readData1 DW, readData2 DW and signExt DW, plus register fields rs 5, rt 5 and rd 5.
REQ-006 SHALL have registered EX outputs exMemRead, exMemWrite, exAluSrc, exRegDst, exRegWrite, exMemToReg (1 each), exFunc 6, exData1 DW, exData2 DW, exImm DW, exRs 5, exRt 5, exRd 5 and exValid 1.
REQ-007 SHALL have combinational hazard outputs stall 1 (hold PC and IF/ID) and ifIdFlush 1 (squash IF/ID).
REQ-008 SHALL have output stallCount 16, a saturating count of stall cycles.

Function
REQ-009 SHALL define hazard = exValid & exMemRead & (exRt != 0) & ((exRt == rs) | (exRt == rt)).
REQ-010 SHALL drive stall = hazard, with no registered delay.
REQ-011 SHALL drive ifIdFlush = (pcSrc != 00) & ~stall, so a stall overrides branch and jump.
REQ-012 SHALL capture all ID inputs into the EX registers on each rising edge when not in reset and stall=0, and SHALL then set exValid=1.
REQ-013 SHALL, on an edge where stall=1, load a bubble:
- all six control outputs 0
- exFunc = 000000 (NOPF)
- exValid = 0
- data and register-field outputs hold their previous values.
REQ-014 SHALL limit a load-use stall to exactly one cycle: the bubble clears exMemRead, so the held instruction proceeds on the next edge.
REQ-015 SHALL NOT trigger a hazard when the EX instruction is a store (exMemRead=0) or when exRt=0.
REQ-016 SHALL NOT bubble the EX stage on branch or jump; the branch instruction itself advances normally.
REQ-017 SHALL increment stallCount by 1 on each edge where stall=1, and SHALL saturate it at 16'hFFFF with no wrap.
REQ-018 SHALL keep the ID-to-EX latency at exactly one clock for every non-stalled instruction.

Reset
REQ-019 SHALL, on any edge with rst=1:
- clear all control outputs, exFunc, exData1, exData2, exImm, exRs, exRt, exRd, exValid and stallCount to 0
- ignore all other inputs on that edge.
REQ-020 SHALL let reset asserted mid-stall take priority, so stall=0 on the cycle after reset.
REQ-021 SHALL hold stall=0 and ifIdFlush=(pcSrc!=00) while exValid=0 after reset.

Structure
REQ-022 SHALL obtain function code NOPF=000000, pcSrc encodings and the register-field width (5) from the shared pipeline package (mips_pkg), which is also used by the control unit.
REQ-023 SHALL place hazard detection in one sub-module, load_use_detect, combinational, with inputs exValid, exMemRead, exRt, rs and rt and output hazard.
REQ-024 SHALL keep the EX register bank in id_ex_stage, with no further hierarchy.

Verification
REQ-025 Reset: rst=1 for 2 cycles with arbitrary inputs -> all outputs 0, stall=0, stallCount=0.
REQ-026 Load-use: lw (memRead=1, rt=5) then add (rs=5) -> stall=1 for 1 cycle, then a bubble in EX (exValid=0, exFunc=0), then the add in EX the next cycle, and stallCount=1.
REQ-027 No hazard:
- lw rt=0 followed by rs=0 -> stall=0
- sw rt=5 followed by rs=5 -> stall=0.
REQ-028 Branch: pcSrc=01 without hazard -> ifIdFlush=1 for the cycle and the beq controls advance to EX unchanged; pcSrc=10 with stall=1 -> ifIdFlush=0.
REQ-029 Saturation: force 70000 consecutive load-use pairs -> stallCount stops at 16'hFFFF.
REQ-030 Reset mid-stall: assert rst while stall=1 -> next cycle exValid=0, stall=0 and stallCount=0.
